// File: rtl/fifo_drain_arbiter_if.sv
// fifo_drain_arbiter_if
//   Bundles the read-side FIFO bank signals and the single valid/ready
//   output stream of the drain arbiter.
//
//   FIFO side : src_empty (per-FIFO empty flag), src_data (per-FIFO
//               first-word-fall-through data, source i at
//               [i*DATA_WIDTH +: DATA_WIDTH]), src_rEn (per-FIFO pop strobe).
//   Out side  : out_valid, out_ready, out_data, out_src (producing source),
//               out_last (final word of a full-length burst).
//
//   master : the arbiter (drives pops and the output stream).
//   slave  : the FIFO bank / consumer side.
interface fifo_drain_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]            src_empty;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_rEn;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          out_last;

  modport master (
    input  src_empty, src_data, out_ready,
    output src_rEn, out_valid, out_data, out_src, out_last
  );

  modport slave (
    output src_empty, src_data, out_ready,
    input  src_rEn, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Drains NUM_SRC async FIFO read ports (all in the rClk domain) into one
//   registered valid/ready stream. One FIFO is granted at a time, picked
//   round-robin, and popped for up to BURST_MAX words per grant.
//
//   Ports:
//     rClk      read-domain clock shared with every FIFO read side
//     arst_n    asynchronous active-low reset
//     enable    allows new grants (a running burst always completes)
//     prio_mask per-source priority class (only with FIFO_ARB_PRIO_EN)
//     busy      a burst is in progress or the output register holds a word
//     bus       fifo_drain_arbiter_if.master: FIFO pops/data and out stream
//
//   Optional feature macro: FIFO_ARB_PRIO_EN
//     When defined, IDLE selection prefers non-empty sources whose prio_mask
//     bit is set, falling back to the remaining non-empty sources.
module fifo_drain_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 8
) (
  input  logic                 rClk,
  input  logic                 arst_n,
  input  logic                 enable,
`ifdef FIFO_ARB_PRIO_EN
  input  logic [NUM_SRC-1:0]   prio_mask,
`endif
  output logic                 busy,
  fifo_drain_arbiter_if.master bus
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [SRC_W-1:0]      grant_q, grant_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;
  logic                  out_last_q, out_last_d;

  logic [NUM_SRC-1:0]    req;
  logic [SRC_W-1:0]      pick;
  logic [SRC_W-1:0]      next_src;
  logic                  can_accept;
  logic                  grant_empty;
  logic                  pop;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [NUM_SRC-1:0]    src_ren;

  // First set bit of req at or after start, wrapping modulo NUM_SRC.
  // The extra index bit keeps start+offset from overflowing before the wrap.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                               input logic [SRC_W-1:0]   start);
    logic [SRC_W-1:0] sel;
    logic [SRC_W:0]   idx;
    logic             found;
    sel   = start;
    found = 1'b0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = {1'b0, start} + (SRC_W+1)'(off);
      if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      if (!found && r[idx[SRC_W-1:0]]) begin
        sel   = idx[SRC_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign req = ~bus.src_empty;

`ifdef FIFO_ARB_PRIO_EN
  logic [NUM_SRC-1:0] req_hi;
  assign req_hi = req & prio_mask;
  assign pick   = (|req_hi) ? rr_pick(req_hi, rr_ptr_q) : rr_pick(req, rr_ptr_q);
`else
  assign pick   = rr_pick(req, rr_ptr_q);
`endif

  assign next_src    = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
  assign can_accept  = ~out_valid_q | bus.out_ready;
  assign grant_empty = bus.src_empty[grant_q];
  assign grant_data  = bus.src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  // Pop is combinational so a word can be replaced in the same cycle it
  // is consumed, giving one word per cycle inside a burst.
  assign pop         = (state_q == BURST) & ~grant_empty & can_accept;

  always_comb begin
    src_ren = '0;
    if (pop) src_ren[grant_q] = 1'b1;
  end

  // Next-state logic for the grant FSM and the output register.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (|req)) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          out_valid_d = 1'b1;
          out_data_d  = grant_data;
          out_src_d   = grant_q;
          out_last_d  = (burst_cnt_q == CNT_W'(BURST_MAX - 1));
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q == CNT_W'(BURST_MAX - 1)) begin
            rr_ptr_d = next_src;
            state_d  = IDLE;
          end
        end else if (grant_empty) begin
          // Source ran dry: end the grant early without flagging last.
          rr_ptr_d = next_src;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge rClk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.src_rEn   = src_ren;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == BURST) | out_valid_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter
//   Directed bench for fifo_drain_arbiter with NUM_SRC=4, DATA_WIDTH=32,
//   BURST_MAX=8. A small array-based FWFT FIFO model feeds the read ports;
//   inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_drain_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BM = 8;

  logic rClk;
  logic arst_n;
  logic enable;
  logic busy;
  logic [NS-1:0] prio_mask;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  fifo_drain_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  fifo_drain_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .rClk      (rClk),
    .arst_n    (arst_n),
    .enable    (enable),
`ifdef FIFO_ARB_PRIO_EN
    .prio_mask (prio_mask),
`endif
    .busy      (busy),
    .bus       (bus)
  );

  initial rClk = 1'b0;
  always #5 rClk = ~rClk;

  // FWFT FIFO model: head word is visible whenever non-empty, pop on rEn.
  logic [DW-1:0] mem [NS][256];
  logic [7:0]    rd_ptr [NS] = '{default: 8'd0};
  logic [7:0]    wr_ptr [NS] = '{default: 8'd0};

  for (genvar g = 0; g < NS; g++) begin : g_fifo
    assign bus.src_empty[g]         = (rd_ptr[g] == wr_ptr[g]);
    assign bus.src_data[g*DW +: DW] = mem[g][rd_ptr[g]];
  end

  always @(posedge rClk) begin
    for (int i = 0; i < NS; i++)
      if (bus.src_rEn[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
  end

  task automatic push(input int s, input logic [DW-1:0] v);
    mem[s][wr_ptr[s]] = v;
    wr_ptr[s] = wr_ptr[s] + 8'd1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NS; i++) wr_ptr[i] = rd_ptr[i];
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable        = en;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge rClk);
    #1;
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    @(negedge rClk);
    clear_fifos();
    arst_n = 1'b1;
  endtask

  int b, r, s, k, n;
  logic [NS-1:0] exp_ren;
  logic exp_valid;

  initial begin
    arst_n        = 1'b0;
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    prio_mask     = '0;

    // Reset values with all FIFOs empty
    cyc();
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_ren",   64'(bus.src_rEn),   64'd0);
    checkOutput("rst_data",  64'(bus.out_data),  64'd0);
    checkOutput("rst_src",   64'(bus.out_src),   64'd0);
    checkOutput("rst_last",  64'(bus.out_last),  64'd0);
    checkOutput("rst_busy",  64'(busy),          64'd0);
    arst_n = 1'b1;

    // enable=0 blocks new grants even with data waiting
    push(1, 32'h1111_0000);
    repeat (3) cyc();
    checkOutput("dis_ren",  64'(bus.src_rEn), 64'd0);
    checkOutput("dis_busy", 64'(busy),        64'd0);
    clear_fifos();
    applyStimulus(1'b1, 1'b1);

    // Empty FIFOs keep the arbiter idle
    repeat (4) cyc();
    checkOutput("idle_ren",  64'(bus.src_rEn), 64'd0);
    checkOutput("idle_busy", 64'(busy),        64'd0);

    $display("[TB] short burst from source 2");
    push(2, 32'hAAAA_0001);
    push(2, 32'hBBBB_0002);
    push(2, 32'hCCCC_0003);
    cyc();
    checkOutput("sb_ren1",   64'(bus.src_rEn),   64'b0100);
    checkOutput("sb_val1",   64'(bus.out_valid), 64'd0);
    checkOutput("sb_busy1",  64'(busy),          64'd1);
    cyc();
    checkOutput("sb_ren2",   64'(bus.src_rEn),   64'b0100);
    checkOutput("sb_val2",   64'(bus.out_valid), 64'd1);
    checkOutput("sb_dataA",  64'(bus.out_data),  64'hAAAA_0001);
    checkOutput("sb_srcA",   64'(bus.out_src),   64'd2);
    checkOutput("sb_lastA",  64'(bus.out_last),  64'd0);
    cyc();
    checkOutput("sb_ren3",   64'(bus.src_rEn),   64'b0100);
    checkOutput("sb_dataB",  64'(bus.out_data),  64'hBBBB_0002);
    cyc();
    checkOutput("sb_ren4",   64'(bus.src_rEn),   64'd0);
    checkOutput("sb_dataC",  64'(bus.out_data),  64'hCCCC_0003);
    checkOutput("sb_srcC",   64'(bus.out_src),   64'd2);
    checkOutput("sb_lastC",  64'(bus.out_last),  64'd0);
    cyc();
    checkOutput("sb_val5",   64'(bus.out_valid), 64'd0);
    checkOutput("sb_busy5",  64'(busy),          64'd0);

    // rr_ptr is now 3: source 3 wins over source 0, then source 0
    push(0, 32'h0000_00A0);
    push(3, 32'h0000_00A3);
    cyc();
    checkOutput("rr_ren3",   64'(bus.src_rEn),   64'b1000);
    cyc();
    checkOutput("rr_data3",  64'(bus.out_data),  64'h0000_00A3);
    checkOutput("rr_src3",   64'(bus.out_src),   64'd3);
    checkOutput("rr_ren_e",  64'(bus.src_rEn),   64'd0);
    cyc();
    checkOutput("rr_val_e",  64'(bus.out_valid), 64'd0);
    cyc();
    checkOutput("rr_ren0",   64'(bus.src_rEn),   64'b0001);
    cyc();
    checkOutput("rr_data0",  64'(bus.out_data),  64'h0000_00A0);
    checkOutput("rr_src0",   64'(bus.out_src),   64'd0);
    pulse_reset();

    $display("[TB] all sources full, round-robin bursts");
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 20; j++) push(i, DW'((i << 16) | j));
    // Grant b starts at cycle 1+9b: 8 pop cycles then one IDLE bubble.
    for (int c = 1; c <= 45; c++) begin
      cyc();
      b = (c - 1) / 9;
      r = (c - 1) % 9;
      s = b % NS;
      exp_ren   = (r <= 7) ? NS'(1 << s) : '0;
      exp_valid = (r >= 1);
      checkOutput("full_ren",   64'(bus.src_rEn),   64'(exp_ren));
      checkOutput("full_valid", 64'(bus.out_valid), 64'(exp_valid));
      if (exp_valid) begin
        k = r - 1;
        n = (b / NS) * BM + k;
        checkOutput("full_data", 64'(bus.out_data), 64'((s << 16) | n));
        checkOutput("full_src",  64'(bus.out_src),  64'(s));
        checkOutput("full_last", 64'(bus.out_last), 64'(k == BM - 1));
      end
    end
    pulse_reset();

    $display("[TB] output stall mid-burst");
    for (int j = 0; j < 8; j++) push(0, 32'hC0DE_0000 + 32'(j));
    cyc();
    checkOutput("st_ren1", 64'(bus.src_rEn), 64'b0001);
    cyc();
    checkOutput("st_w0", 64'(bus.out_data), 64'hC0DE_0000);
    cyc();
    checkOutput("st_w1", 64'(bus.out_data), 64'hC0DE_0001);
    @(negedge rClk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("st_hold_ren",  64'(bus.src_rEn),   64'd0);
    checkOutput("st_hold_data", 64'(bus.out_data),  64'hC0DE_0002);
    for (int j = 0; j < 4; j++) begin
      cyc();
      checkOutput("st_hold_ren",  64'(bus.src_rEn),   64'd0);
      checkOutput("st_hold_val",  64'(bus.out_valid), 64'd1);
      checkOutput("st_hold_data", 64'(bus.out_data),  64'hC0DE_0002);
    end
    @(negedge rClk);
    applyStimulus(1'b1, 1'b1);
    checkOutput("st_res_ren",  64'(bus.src_rEn),  64'b0001);
    checkOutput("st_res_data", 64'(bus.out_data), 64'hC0DE_0002);
    for (int j = 3; j < 8; j++) begin
      cyc();
      checkOutput("st_data", 64'(bus.out_data), 64'hC0DE_0000 + 64'(j));
      checkOutput("st_last", 64'(bus.out_last), 64'(j == 7));
    end
    cyc();
    checkOutput("st_end_val",  64'(bus.out_valid), 64'd0);
    checkOutput("st_end_busy", 64'(busy),          64'd0);

    $display("[TB] reset mid-burst");
    for (int j = 0; j < 8; j++) push(1, 32'hBEEF_0000 + 32'(j));
    cyc();
    checkOutput("mr_ren1", 64'(bus.src_rEn), 64'b0010);
    repeat (4) cyc();
    checkOutput("mr_w3", 64'(bus.out_data), 64'hBEEF_0003);
    arst_n = 1'b0;
    #1;
    checkOutput("mr_val",  64'(bus.out_valid), 64'd0);
    checkOutput("mr_ren",  64'(bus.src_rEn),   64'd0);
    checkOutput("mr_busy", 64'(busy),          64'd0);
    checkOutput("mr_data", 64'(bus.out_data),  64'd0);
    push(0, 32'h0000_5555);
    @(negedge rClk);
    arst_n = 1'b1;
    cyc();
    checkOutput("mr_restart_ren", 64'(bus.src_rEn), 64'b0001);
    cyc();
    checkOutput("mr_restart_data", 64'(bus.out_data), 64'h0000_5555);
    checkOutput("mr_restart_src",  64'(bus.out_src),  64'd0);
    pulse_reset();

`ifdef FIFO_ARB_PRIO_EN
    $display("[TB] priority class selection");
    prio_mask = 4'b1000;
    push(0, 32'h0000_0F00);
    push(3, 32'h0000_0F03);
    cyc();
    checkOutput("pr_ren3",  64'(bus.src_rEn),  64'b1000);
    cyc();
    checkOutput("pr_data3", 64'(bus.out_data), 64'h0000_0F03);
    cyc();
    cyc();
    checkOutput("pr_ren0",  64'(bus.src_rEn),  64'b0001);
    cyc();
    checkOutput("pr_data0", 64'(bus.out_data), 64'h0000_0F00);
    checkOutput("pr_src0",  64'(bus.out_src),  64'd0);
    prio_mask = '0;
    pulse_reset();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Read-side scheduler that drains NUM_SRC async_fifo read ports into one valid/ready output stream, entirely in the rClk domain.
- Grants one FIFO at a time, in round-robin order, for bursts of up to BURST_MAX words.
- Drives each FIFO's rEn and muxes its first-word-fall-through rData into a registered output stage.
- Sits between a bank of clock-crossing FIFOs and a shared downstream consumer (DMA/packer).

Parameters:
- NUM_SRC, 4, number of FIFO read ports; must be 2 or more.
- DATA_WIDTH, 32, FIFO and output data width.
- BURST_MAX, 8, maximum words popped per grant; must be 1 or more.

Ports:
- rClk  input  1  read-domain clock, shared with all FIFO read sides.
- arst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows new grants.
- src_empty  input  NUM_SRC  per-FIFO empty flag.
- src_data  input  NUM_SRC*DATA_WIDTH  per-FIFO rData; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_rEn  output  NUM_SRC  per-FIFO pop strobe; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_WIDTH  output word.
- out_src  output  max(1,$clog2(NUM_SRC))  index of the source that produced out_data.
- out_last  output  1  word is the BURST_MAX-th word of its grant.
- busy  output  1  high when state is BURST or out_valid is high.

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, src_rEn=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0. Reset is asynchronous and applies mid-burst; the word in the output register is discarded.
- FIFO contract:
  - src_data[i] is valid whenever src_empty[i]=0.
  - A pop (src_rEn[i]=1 on a clock edge) consumes that word.
  - src_empty[i] is correct on the next cycle, so no extra guard is needed.
- can_accept = ~out_valid | out_ready.
- IDLE:
  - If enable=1 and any src_empty bit is 0, select the first non-empty index searching from rr_ptr upward, wrapping modulo NUM_SRC.
  - Register the selection into grant, clear burst_cnt, go to BURST.
  - No pop occurs in IDLE.
- BURST:
  - src_rEn[grant] = ~src_empty[grant] & can_accept, combinational. All other bits are 0.
  - On a pop: out_data <= src_data[grant], out_src <= grant, out_valid <= 1, out_last <= (burst_cnt == BURST_MAX-1), burst_cnt <= burst_cnt+1.
  - If the pop makes burst_cnt reach BURST_MAX: rr_ptr <= grant+1 (mod NUM_SRC), go to IDLE.
  - If src_empty[grant]=1 (no pop possible): rr_ptr <= grant+1, go to IDLE. The grant ends early and out_last is not raised.
  - A stalled output (out_valid=1, out_ready=0) holds the burst with no pop, no timeout and no state change.
- Output register: when out_valid & out_ready and there is no pop in the same cycle, out_valid <= 0. A pop and a consume in the same cycle replace the word, giving full throughput.
- Latency:
  - FIFO going non-empty in IDLE at cycle 0: grant at cycle 1, src_rEn at cycle 1, out_valid at cycle 2.
  - Between grants there is exactly one IDLE bubble cycle.
  - Sustained throughput is BURST_MAX/(BURST_MAX+1) words per cycle with all sources full.
- enable=0 during BURST: the current grant runs to completion; no new grant is issued from IDLE.
- Fairness: a source that stays non-empty is granted within NUM_SRC-1 other grants.
- rr_ptr wraps from NUM_SRC-1 to 0.
- burst_cnt width is $clog2(BURST_MAX+1).

Optional Feature:
- Macro: FIFO_ARB_PRIO_EN.
- Defined:
  - Adds input prio_mask [NUM_SRC].
  - IDLE selection searches the non-empty sources with prio_mask=1 first (round-robin from rr_ptr within that class). Only if none exist does it search the remaining non-empty sources (round-robin from rr_ptr).
  - prio_mask is sampled in IDLE only.
- Undefined: the port is absent and selection is pure round-robin as above.

Test Plan:
- Reset with all FIFOs empty -> all outputs 0, src_rEn=0, state stays IDLE indefinitely.
- Source 2 holds 3 words (A,B,C), out_ready=1, BURST_MAX=8 -> src_rEn[2] high for cycles 1-3; out_data A,B,C on cycles 2-4 with out_src=2 and out_last=0; grant releases and rr_ptr=3.
- All 4 sources hold 20 words, out_ready=1 -> grants in order 0,1,2,3,0; 8 words each; out_last on every 8th word; one bubble cycle between bursts.
- Source 0 bursting, out_ready low for 5 cycles mid-burst -> src_rEn=0 and out_data held for those 5 cycles; burst resumes with no word lost or duplicated.
- arst_n asserted after 4 words of a burst -> out_valid=0 and src_rEn=0 immediately; after release, arbitration restarts from rr_ptr=0.
- FIFO_ARB_PRIO_EN defined, prio_mask=4'b1000, sources 0 and 3 non-empty, rr_ptr=0 -> source 3 is granted first, then source 0.
